// File: rtl/calc_pkg.sv
// Shared types and constants for the calculadora stimulus checker.
// Holds the MODO encodings, the data width and the checker FSM states.
package calc_pkg;

  localparam int CALC_W = 4;

  typedef enum logic [1:0] {
    MODO_ADD = 2'b00,
    MODO_SUB = 2'b01,
    MODO_AND = 2'b10,
    MODO_OR  = 2'b11
  } modo_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/calc_ref_model.sv
// Combinational golden model of the 4-bit calculadora datapath.
// Ports: a, b operands; MODO op select; exp = expected result (wraps mod 16).
module calc_ref_model
  import calc_pkg::*;
(
  input  logic [CALC_W-1:0] a,
  input  logic [CALC_W-1:0] b,
  input  logic [1:0]        MODO,
  output logic [CALC_W-1:0] exp
);

  always_comb begin
    unique case (MODO)
      MODO_ADD: exp = a + b;
      MODO_SUB: exp = a - b;
      MODO_AND: exp = a & b;
      MODO_OR:  exp = a | b;
    endcase
  end

endmodule

// File: rtl/calc_stim_checker.sv
// On-chip self-checking initiator for calculadora: sweeps {MODO,a,b},
// waits LAT cycles, checks c, and counts passes/fails.
// Ports: clk, rst (sync, active-low), start; a/b/MODO to DUT, c from DUT;
// busy, done, pass_cnt, fail_cnt. Define CALC_CHECK_FIRST_FAIL_EN to add
// ff_valid/ff_vec/ff_got/ff_exp first-mismatch capture outputs.
module calc_stim_checker
  import calc_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int N_VEC = 1024,
  parameter int CNT_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [CALC_W-1:0] a,
  output logic [CALC_W-1:0] b,
  output logic [1:0]        MODO,
  input  logic [CALC_W-1:0] c,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt
`ifdef CALC_CHECK_FIRST_FAIL_EN
  ,
  output logic              ff_valid,
  output logic [9:0]        ff_vec,
  output logic [CALC_W-1:0] ff_got,
  output logic [CALC_W-1:0] ff_exp
`endif
);

  localparam logic [2:0] LAT_V    = 3'(LAT);
  localparam logic [9:0] LAST_IDX = 10'(N_VEC - 1);

  state_e state_q;
  state_e state_d;

  logic [9:0]        idx_q;
  logic [2:0]        wcnt_q;
  logic [CALC_W-1:0] exp_v;
  logic              match;
  logic              last;

  logic clr;
  logic ld;
  logic dec;
  logic chk;
  logic busy_d;
  logic done_d;

  calc_ref_model u_ref (
    .a    (a),
    .b    (b),
    .MODO (MODO),
    .exp  (exp_v)
  );

  assign match = (c == exp_v);
  assign last  = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DONE:    if (start) state_d = DRIVE;
      DRIVE:   state_d = WAIT;
      WAIT:    if (wcnt_q == 3'd1) state_d = CHECK;
      CHECK:   state_d = last ? DONE : DRIVE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up
  // with the state register rather than lagging it.
  always_comb begin
    clr = 1'b0;
    ld  = 1'b0;
    dec = 1'b0;
    chk = 1'b0;
    unique case (state_q)
      IDLE:    clr = start;
      DONE:    clr = start;
      DRIVE:   ld  = 1'b1;
      WAIT:    dec = 1'b1;
      CHECK:   chk = 1'b1;
      default: ;
    endcase
    busy_d = (state_d == DRIVE) || (state_d == WAIT) ||
             (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a        <= '0;
      b        <= '0;
      MODO     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      idx_q    <= '0;
      wcnt_q   <= '0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (clr) begin
        pass_cnt <= '0;
        fail_cnt <= '0;
        idx_q    <= '0;
      end
      if (ld) begin
        {MODO, a, b} <= idx_q;
        wcnt_q       <= LAT_V;
      end
      if (dec) wcnt_q <= wcnt_q - 3'd1;
      if (chk) begin
        if (match) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        end
        if (!last) idx_q <= idx_q + 10'd1;
      end
    end
  end

`ifdef CALC_CHECK_FIRST_FAIL_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ff_valid <= 1'b0;
      ff_vec   <= '0;
      ff_got   <= '0;
      ff_exp   <= '0;
    end else if (clr) begin
      ff_valid <= 1'b0;
      ff_vec   <= '0;
      ff_got   <= '0;
      ff_exp   <= '0;
    end else if (chk && !match && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_vec   <= idx_q;
      ff_got   <= c;
      ff_exp   <= exp_v;
    end
  end
`endif

endmodule
